// File: rtl/floor_request_scheduler.sv
// floor_request_scheduler
// Turns raw call buttons into pending requests and presents one SCAN-ordered
// one-hot target floor to the elevator controller.
// Ports:
//   clk, rst     clock and asynchronous active-high reset
//   call_btn     raw asynchronous call buttons, bit i = floor i
//   floor_pos    one-hot floor sensor, zero between floors
//   door_open    door status from the elevator controller
//   target       registered one-hot floor request (zero = no request)
//   pending      registered pending-request lamps
//   req_valid    registered, equals |target
//   dir_up       registered, high while moving up
//   dir_dn       registered, high while moving down
module floor_request_scheduler #(
  parameter int unsigned NFLOORS = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NFLOORS-1:0] call_btn,
  input  logic [NFLOORS-1:0] floor_pos,
  input  logic               door_open,
  output logic [NFLOORS-1:0] target,
  output logic [NFLOORS-1:0] pending,
  output logic               req_valid,
  output logic               dir_up,
  output logic               dir_dn
);

  localparam int unsigned IW = (NFLOORS > 1) ? $clog2(NFLOORS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } state_t;

  state_t state, state_next;

  logic [NFLOORS-1:0] s1, s2, s3;
  logic [NFLOORS-1:0] last_floor;
  logic [NFLOORS-1:0] press, serve, pending_next;
  logic [NFLOORS-1:0] above, below, here;
  logic [NFLOORS-1:0] up_tgt, dn_tgt, target_next;
  logic [IW-1:0]      cur_idx, up_idx, dn_idx, dist_up, dist_dn;
  logic               any_above, any_below, pos_onehot;

  // Two-flop synchronizer plus one extra stage for rising-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= call_btn;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign press = s2 & ~s3;

  // Zero (between floors) or multi-hot (sensor fault) keeps the last good floor
  assign pos_onehot = (floor_pos != '0) &&
                      ((floor_pos & (floor_pos - NFLOORS'(1))) == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_floor <= NFLOORS'(1);
    end else if (pos_onehot) begin
      last_floor <= floor_pos;
    end
  end

  // A clear at the served floor wins over a press arriving in the same cycle
  assign serve        = {NFLOORS{door_open}} & last_floor;
  assign pending_next = (pending | press) & ~serve;

  // Split requests around the car and find the nearest one on each side
  always_comb begin
    cur_idx = '0;
    for (int i = 0; i < NFLOORS; i++) begin
      if (last_floor[i]) cur_idx = IW'(i);
    end

    above = '0;
    below = '0;
    for (int i = 0; i < NFLOORS; i++) begin
      if (IW'(i) > cur_idx) above[i] = pending_next[i];
      if (IW'(i) < cur_idx) below[i] = pending_next[i];
    end
    here = pending_next & last_floor;

    any_above = |above;
    any_below = |below;

    up_idx = '0;
    for (int i = NFLOORS - 1; i >= 0; i--) begin
      if (above[i]) up_idx = IW'(i);
    end
    dn_idx = '0;
    for (int i = 0; i < NFLOORS; i++) begin
      if (below[i]) dn_idx = IW'(i);
    end

    dist_up = up_idx - cur_idx;
    dist_dn = cur_idx - dn_idx;

    up_tgt = '0;
    dn_tgt = '0;
    for (int i = 0; i < NFLOORS; i++) begin
      up_tgt[i] = any_above && (IW'(i) == up_idx);
      dn_tgt[i] = any_below && (IW'(i) == dn_idx);
    end
  end

  // SCAN next-state and next-target selection
  always_comb begin
    state_next  = state;
    target_next = '0;
    case (state)
      IDLE: begin
        if (!any_above && !any_below) begin
          target_next = here;
        end else if (any_above && (!any_below || (dist_up <= dist_dn))) begin
          state_next  = UP;
          target_next = up_tgt;
        end else begin
          state_next  = DOWN;
          target_next = dn_tgt;
        end
      end
      UP: begin
        if (any_above) begin
          target_next = up_tgt;
        end else if (any_below) begin
          state_next  = DOWN;
          target_next = dn_tgt;
        end else begin
          state_next  = IDLE;
          target_next = here;
        end
      end
      DOWN: begin
        if (any_below) begin
          target_next = dn_tgt;
        end else if (any_above) begin
          state_next  = UP;
          target_next = up_tgt;
        end else begin
          state_next  = IDLE;
          target_next = here;
        end
      end
      default: begin
        state_next  = IDLE;
        target_next = '0;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pending   <= '0;
      target    <= '0;
      req_valid <= 1'b0;
      dir_up    <= 1'b0;
      dir_dn    <= 1'b0;
    end else begin
      state     <= state_next;
      pending   <= pending_next;
      target    <= target_next;
      req_valid <= |target_next;
      dir_up    <= (state_next == UP);
      dir_dn    <= (state_next == DOWN);
    end
  end

endmodule

// File: tb/tb_floor_request_scheduler.sv
// Directed bench for floor_request_scheduler with a per-cycle behavioural model.
module tb_floor_request_scheduler;

  localparam int unsigned NF  = 3;
  localparam int          NFI = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [NF-1:0] call_btn;
  logic [NF-1:0] floor_pos;
  logic          door_open;
  logic [NF-1:0] target;
  logic [NF-1:0] pending;
  logic          req_valid;
  logic          dir_up;
  logic          dir_dn;

  int vectors     = 0;
  int miscompares = 0;
  bit cmp_en      = 1'b0;

  floor_request_scheduler #(.NFLOORS(NF)) dut (
    .clk       (clk),
    .rst       (rst),
    .call_btn  (call_btn),
    .floor_pos (floor_pos),
    .door_open (door_open),
    .target    (target),
    .pending   (pending),
    .req_valid (req_valid),
    .dir_up    (dir_up),
    .dir_dn    (dir_dn)
  );

  always #5 clk = ~clk;

  // Behavioural model: floors as integers, requests as a flag per floor
  bit [NF-1:0] m_s1, m_s2, m_s3;
  bit          m_pend [NF];
  int          m_last;
  int          m_state;   // 0 idle, 1 up, 2 down
  int          m_tgt;     // -1 means no request

  task automatic model_step();
    int  up_f, dn_f, n, idx;
    bit  prs [NF];
    for (int i = 0; i < NFI; i++) prs[i] = m_s2[i] && !m_s3[i];
    for (int i = 0; i < NFI; i++)
      m_pend[i] = (m_pend[i] || prs[i]) && !(door_open && (i == m_last));
    up_f = -1;
    dn_f = -1;
    for (int d = 1; d < NFI; d++) begin
      if (up_f < 0 && m_last + d < NFI && m_pend[m_last + d]) up_f = m_last + d;
      if (dn_f < 0 && m_last - d >= 0 && m_pend[m_last - d]) dn_f = m_last - d;
    end
    case (m_state)
      0: begin
        if (up_f < 0 && dn_f < 0) m_tgt = m_pend[m_last] ? m_last : -1;
        else if (dn_f < 0 || (up_f >= 0 && (up_f - m_last) <= (m_last - dn_f))) begin
          m_state = 1; m_tgt = up_f;
        end else begin
          m_state = 2; m_tgt = dn_f;
        end
      end
      1: begin
        if (up_f >= 0) m_tgt = up_f;
        else if (dn_f >= 0) begin m_state = 2; m_tgt = dn_f; end
        else begin m_state = 0; m_tgt = m_pend[m_last] ? m_last : -1; end
      end
      default: begin
        if (dn_f >= 0) m_tgt = dn_f;
        else if (up_f >= 0) begin m_state = 1; m_tgt = up_f; end
        else begin m_state = 0; m_tgt = m_pend[m_last] ? m_last : -1; end
      end
    endcase
    n   = 0;
    idx = 0;
    for (int i = 0; i < NFI; i++) if (floor_pos[i]) begin n++; idx = i; end
    if (n == 1) m_last = idx;
    m_s3 = m_s2;
    m_s2 = m_s1;
    m_s1 = call_btn;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_s3 = '0;
      for (int i = 0; i < NFI; i++) m_pend[i] = 1'b0;
      m_last  = 0;
      m_state = 0;
      m_tgt   = -1;
    end else begin
      model_step();
    end
  end

  function automatic logic [NF-1:0] model_target();
    logic [NF-1:0] v;
    v = '0;
    if (m_tgt >= 0) v[m_tgt] = 1'b1;
    return v;
  endfunction

  function automatic logic [NF-1:0] model_pending();
    logic [NF-1:0] v;
    for (int i = 0; i < NFI; i++) v[i] = m_pend[i];
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model
  always @(posedge clk) begin
    #1;
    if (cmp_en) begin
      chk("model_target",    8'(target),    8'(model_target()));
      chk("model_pending",   8'(pending),   8'(model_pending()));
      chk("model_req_valid", 8'(req_valid), 8'(m_tgt >= 0));
      chk("model_dir_up",    8'(dir_up),    8'(m_state == 1));
      chk("model_dir_dn",    8'(dir_dn),    8'(m_state == 2));
    end
  end

  // Hand-computed literal expectations
  task automatic expect_out(input string name, input logic [NF-1:0] t,
                            input logic [NF-1:0] p, input logic du, input logic dd);
    chk({name, "_target"},    8'(target),    8'(t));
    chk({name, "_pending"},   8'(pending),   8'(p));
    chk({name, "_req_valid"}, 8'(req_valid), 8'(|t));
    chk({name, "_dir_up"},    8'(dir_up),    8'(du));
    chk({name, "_dir_dn"},    8'(dir_dn),    8'(dd));
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [NF-1:0] mask);
    call_btn = mask;
    step(3);
    call_btn = '0;
    step(1);
  endtask

  initial begin
    rst       = 1'b1;
    call_btn  = '0;
    floor_pos = 3'b001;
    door_open = 1'b0;
    step(2);
    expect_out("reset", 3'b000, 3'b000, 1'b0, 1'b0);
    rst    = 1'b0;
    cmp_en = 1'b1;

    // Single call from floor 0 to floor 2
    call_btn = 3'b100;
    step(2);
    expect_out("latency_early", 3'b000, 3'b000, 1'b0, 1'b0);
    step(1);
    expect_out("single_call", 3'b100, 3'b100, 1'b1, 1'b0);
    step(2);
    call_btn = '0;
    step(2);
    floor_pos = 3'b100;
    door_open = 1'b1;
    step(2);
    expect_out("single_serve", 3'b000, 3'b000, 1'b0, 1'b0);
    door_open = 1'b0;

    // SCAN: moving up past floor 1 with a call behind the car
    floor_pos = 3'b001;
    step(1);
    press(3'b100);
    floor_pos = 3'b010;
    step(1);
    press(3'b001);
    expect_out("scan_hold", 3'b100, 3'b101, 1'b1, 1'b0);
    floor_pos = 3'b100;
    door_open = 1'b1;
    step(2);
    expect_out("scan_reverse", 3'b001, 3'b001, 1'b0, 1'b1);
    floor_pos = 3'b001;
    step(2);
    expect_out("scan_done", 3'b000, 3'b000, 1'b0, 1'b0);
    door_open = 1'b0;

    // Pickup en route while between floors
    press(3'b100);
    floor_pos = 3'b000;
    step(1);
    press(3'b010);
    expect_out("pickup", 3'b010, 3'b110, 1'b1, 1'b0);
    floor_pos = 3'b010;
    door_open = 1'b1;
    step(2);
    expect_out("pickup_served", 3'b100, 3'b100, 1'b1, 1'b0);

    // Press at the open-door floor, then keep holding after the door closes
    call_btn = 3'b010;
    step(6);
    door_open = 1'b0;
    step(4);
    expect_out("set_clear_held", 3'b100, 3'b100, 1'b1, 1'b0);
    call_btn = '0;
    step(2);
    floor_pos = 3'b100;
    door_open = 1'b1;
    step(2);
    door_open = 1'b0;
    step(1);
    expect_out("floor2_served", 3'b000, 3'b000, 1'b0, 1'b0);

    // Multi-hot sensor ignored, then equidistant calls go up
    floor_pos = 3'b010;
    step(1);
    floor_pos = 3'b110;
    step(1);
    press(3'b101);
    expect_out("tie_up", 3'b100, 3'b101, 1'b1, 1'b0);

    // Asynchronous reset mid-run with a button held across release
    call_btn  = 3'b010;
    floor_pos = 3'b000;
    rst = 1'b1;
    #1;
    expect_out("async_reset", 3'b000, 3'b000, 1'b0, 1'b0);
    step(2);
    rst = 1'b0;
    step(3);
    expect_out("reset_press", 3'b010, 3'b010, 1'b1, 1'b0);
    call_btn = '0;
    step(2);
    floor_pos = 3'b010;
    door_open = 1'b1;
    step(2);
    expect_out("final_idle", 3'b000, 3'b000, 1'b0, 1'b0);
    door_open = 1'b0;
    step(2);

    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/floor_request_scheduler.md
# floor_request_scheduler

Upstream stage of the elevator controller: captures raw car/hall call buttons, holds them as pending requests, and presents a single one-hot target floor on the bus that drives the controller's `button` input. Requests are served in SCAN order (continue in the current direction, then reverse). A request clears when the controller opens the door at that floor.

## Interface
- `NFLOORS`, default 3: number of floors; width of all floor vectors. Legal range is 2..16.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `call_btn` in NFLOORS: raw asynchronous call buttons; bit i means floor i.
- `floor_pos` in NFLOORS: one-hot floor sensor. All-zero means between floors.
- `door_open` in 1: door status from the elevator controller.
- `target` out NFLOORS: one-hot registered floor request to the controller. All-zero means no request.
- `pending` out NFLOORS: registered pending-request lamps.
- `req_valid` out 1: registered; equals |target.
- `dir_up` out 1: registered; high in state UP.
- `dir_dn` out 1: registered; high in state DOWN.

## Operation
- **Input capture.** Each `call_btn` bit passes through a 2-flop synchronizer (`s1`, `s2`). A third flop `s3` supports rising-edge detection: `press[i] = s2[i] & ~s3[i]`.
- **Last floor.** A register holds the last floor reached.
  - Loads `floor_pos` when `floor_pos` is exactly one-hot.
  - Holds when `floor_pos` is zero or multi-hot (sensor fault).
- **Serve condition.** `serve[i] = door_open & last_floor[i]`.
- **Pending update.** `pending_next = (pending | press) & ~serve`. Clear wins over a simultaneous press at the same floor.
- **Classification.** Split the pending vector relative to `last_floor`:
  - `above` = pending bits with index greater than the last floor.
  - `below` = pending bits with index less than the last floor.
  - `here` = pending bit at the last floor.
- **State machine.** States are IDLE, UP and DOWN, evaluated every cycle on `pending_next`.
  - **IDLE**
    - If `above` and `below` are both empty and `here` is set: target = `last_floor`; stay in IDLE.
    - Otherwise go to whichever direction has the nearest pending floor. At equal distance, go UP.
    - If nothing is pending: target = 0; stay in IDLE.
  - **UP**
    - target = lowest floor in `above`.
    - If `above` is empty: go to DOWN if `below` is non-empty; otherwise go to IDLE, with target = `here` if set, else 0.
  - **DOWN**
    - target = highest floor in `below`.
    - If `below` is empty: go to UP if `above` is non-empty; otherwise go to IDLE, with target = `here` if set, else 0.
- **Retargeting.** A new press nearer in the current direction replaces the target on the next update (pickup en route). Presses behind the car wait for reversal.
- **Output encoding.** `target` is always one-hot or zero, never multi-hot.

## Timing
- **Reset values** (asynchronous, immediate):
  - `s1`, `s2`, `s3` = 0.
  - `pending` = 0, `target` = 0, `req_valid` = 0.
  - `last_floor` = one-hot floor 0.
  - state = IDLE, `dir_up` = 0, `dir_dn` = 0.
- **Reset during a press.** A raw press held across reset release is seen as a new edge once it propagates through the synchronizer.
- **Latency.** Raw press sampled at edge k:
  - `s2` high after edge k+1.
  - `pending` set at edge k+2.
  - `target`, `state` and direction outputs update at edge k+2, computed from `pending_next`.
- **Clear.** `door_open` high with the matching `last_floor` at edge m: the `pending` bit clears at edge m. The next target is presented in the same update.
- **Held buttons.** A button held continuously registers exactly once. A repeat requires release and re-press, with at least 1 cycle low after synchronization.
- **Between floors.** A zero `floor_pos` never changes `last_floor`, so direction decisions use the last confirmed floor.
- **Throughput.** One state transition per cycle. No handshake: the controller samples `target` as a level.

## Test plan
Default `NFLOORS`=3 in all scenarios.
- **Reset:** assert `rst` mid-run with `pending`=3'b101 → same cycle `pending`=0, `target`=0, `dir_up`=`dir_dn`=0. After release, `last_floor` = floor 0.
- **Single call:** `floor_pos`=3'b001, pulse `call_btn`=3'b100 for 5 cycles.
  - `pending`=3'b100 and `target`=3'b100, `dir_up`=1 exactly 2 edges after the first sampling edge.
  - Then drive `floor_pos`=3'b100 and `door_open`=1 → `pending`=0, `target`=0, state IDLE.
- **SCAN order:** at floor 1 moving UP with `pending`=3'b100, press floor 0.
  - `target` stays 3'b100.
  - After serving floor 2, state becomes DOWN and `target`=3'b001.
- **Pickup en route:** at floor 0, target floor 2 (UP); press floor 1 before arrival → `target` changes to 3'b010. Floor 2 stays pending.
- **Simultaneous set/clear:** press floor 1 in the same cycle that `door_open`=1 at floor 1 → `pending[1]`=0 afterward. A held button does not re-set the bit.
- **Sensor fault and tie:**
  - `floor_pos`=3'b011 → `last_floor` unchanged.
  - At floor 1 in IDLE, press floors 0 and 2 simultaneously → state UP, `target`=3'b100.
